// File: rtl/result_shift_out.sv
// Parallel-to-serial output stage: captures WIDTH compressor columns and shifts them out LSB-first
// under a valid/ready handshake. Define SHIFT_OUT_PARITY_EN to append an even-parity beat.
module result_shift_out #(
   parameter int WIDTH = 36,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] dst_in,
   input  logic             load,
   input  logic             sout_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             busy,
   output logic             done
);

`ifdef SHIFT_OUT_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
   logic par;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t           state, next_state;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;
   logic             capture;
   logic             advance;
   logic             last_data;
   logic             frame_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      sout       = 1'b0;
      sout_valid = 1'b0;
      sout_last  = 1'b0;
      busy       = 1'b0;
      capture    = 1'b0;
      advance    = 1'b0;
      last_data  = 1'b0;
      frame_end  = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               capture    = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            sout       = shreg[0];
            sout_valid = 1'b1;
            busy       = 1'b1;
            advance    = sout_ready;
            last_data  = (cnt == CNT_W'(WIDTH - 1));
`ifdef SHIFT_OUT_PARITY_EN
            if (advance && last_data) next_state = PAR;
`else
            sout_last = last_data;
            if (advance && last_data) begin
               next_state = IDLE;
               frame_end  = 1'b1;
            end
`endif
         end
`ifdef SHIFT_OUT_PARITY_EN
         PAR: begin
            sout       = par;
            sout_valid = 1'b1;
            sout_last  = 1'b1;
            busy       = 1'b1;
            if (sout_ready) begin
               next_state = IDLE;
               frame_end  = 1'b1;
            end
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   // done is registered so it lands in the cycle after the final accepted beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
         done  <= 1'b0;
`ifdef SHIFT_OUT_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         done <= frame_end;
         if (capture) begin
            shreg <= dst_in;
            cnt   <= '0;
`ifdef SHIFT_OUT_PARITY_EN
            par   <= ^dst_in;
`endif
         end else if (advance) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            cnt   <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/result_shift_out.md
Name: result_shift_out

Overview:
- Parallel-to-serial output stage for compressor results; the opposite end of the input shift_register path.
- Captures the compressor's WIDTH one-bit column outputs (dst0..dstN, concatenated with dst0 as bit 0) in a single cycle.
- Shifts the captured word out LSB-first (column 0 first) on one pin, under a valid/ready handshake.
- Lets the compressor testbench and FPGA wrapper read a wide result through one serial output.

Parameters:
- WIDTH, 36, number of result columns captured and shifted (must be >= 2).
- CNT_W, $clog2(WIDTH+1), width of the internal beat counter (derived; do not override).

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- dst_in  input  WIDTH  parallel compressor result; bit i = column i.
- load  input  1  capture request; honoured only in IDLE.
- sout_ready  input  1  downstream accepts the current serial beat.
- sout  output  1  current serial data bit.
- sout_valid  output  1  sout holds a valid beat.
- sout_last  output  1  current beat is the final beat of the frame.
- busy  output  1  a frame is captured and not yet fully sent.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE, shreg=0, cnt=0, and every output 0 (sout, sout_valid, sout_last, busy, done).
- States: IDLE, SHIFT, plus PAR when SHIFT_OUT_PARITY_EN is defined. All state, shreg and cnt are registered.
- IDLE:
  - load=1 at a clock edge: shreg<=dst_in, cnt<=0, state<=SHIFT.
  - busy=1 and sout_valid=1 from the next cycle, so first-beat latency is 1 cycle after load.
- SHIFT:
  - sout=shreg[0], sout_valid=1, busy=1, sout_last=(cnt==WIDTH-1) (without parity).
  - A handshake is sout_valid && sout_ready at a clock edge.
  - On handshake: shreg<=shreg>>1 (zero fill), cnt<=cnt+1.
  - sout_ready=0: shreg, cnt and sout hold, and sout_valid stays 1. Valid is never withdrawn.
  - Handshake on beat WIDTH-1: state<=IDLE (or PAR if the parity option is on) and done=1 for exactly the next cycle.
- Frame length: exactly WIDTH handshakes, or WIDTH+1 with parity. Back-to-back with sout_ready=1, a frame takes WIDTH cycles of sout_valid.
- load while busy: ignored. The captured word is unaffected, and load is not queued.
- load in the same cycle as the final handshake: ignored, because state is still SHIFT. The next load is accepted in the following cycle (IDLE), and done and the new capture may coincide.
- dst_in changes after capture: no effect on the frame in flight.
- Reset mid-frame: immediate abort, no done pulse, and all outputs return to 0.
- Counter: cnt never exceeds WIDTH and returns to 0 only on a new load or reset. Its value in IDLE is don't-care for outputs.
- done and busy are mutually exclusive in the done cycle (busy=0).

Optional Feature:
- Macro: SHIFT_OUT_PARITY_EN.
- Defined:
  - At capture, par<=^dst_in (even parity over the WIDTH bits).
  - After the WIDTH data beats, state PAR drives sout=par, sout_valid=1 and sout_last=1, under the same handshake/stall rules.
  - sout_last is 0 on data beat WIDTH-1.
  - done pulses the cycle after the parity beat is accepted.
- Undefined: PAR state and par register are absent, and the frame is WIDTH beats with sout_last on beat WIDTH-1.

Test Plan:
- Basic frame: reset, dst_in=36'h0_0000_0001, load 1 cycle, sout_ready=1 held → beat0 sout=1, beats 1..35 sout=0, sout_last only on beat 35, done=1 exactly one cycle after beat 35, busy=0 in that cycle.
- Backpressure: dst_in=36'hA_5A5A_5A5A, sout_ready toggles 1,0,0,1,… → serial sequence equals bits 0..35 of the word with no drop or duplicate, sout_valid continuously 1 during the frame, and sout stable while ready=0.
- Ignored loads: after loading 36'hF_0000_000F, change dst_in to 0 and pulse load on beats 3 and 35 (the final handshake) → transmitted word is still 36'hF_0000_000F, and a load one cycle after the final beat captures the new value.
- Reset mid-frame: assert rst during beat 10 → all outputs 0 asynchronously and no done pulse; a new load after release restarts from beat 0.
- Parity (SHIFT_OUT_PARITY_EN): dst_in=36'h0_0000_0007 → 37 beats, beat36 sout=1, sout_last on beat36 only; with dst_in=36'h0_0000_0003, beat36 sout=0.
